// File: rtl/multi_gate_pkg.sv
// ---------------------------------------------------------------------------
// multi_gate_pkg
// Shared definitions for the multi-input reduction-gate demo:
//   - mode encodings MODE_AND..MODE_XNOR (binary, as shown on the mode LEDs)
//   - MODE_COUNT / MODE_W, and MAX_INPUTS (widest supported switch vector)
//   - gate_eval(): reduction of the low n bits of a vector for a given mode
// ---------------------------------------------------------------------------
package multi_gate_pkg;

    localparam int MODE_COUNT = 6;
    localparam int MODE_W     = 3;
    localparam int MAX_INPUTS = 16;

    typedef enum logic [MODE_W-1:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5
    } mode_e;

    // Reduce the low n bits of vec. Bits at and above n are ignored so one
    // function serves every legal input count. Codes 6/7 yield 0.
    function automatic logic gate_eval(
        input logic [MODE_W-1:0]     mode,
        input logic [MAX_INPUTS-1:0] vec,
        input int unsigned           n
    );
        logic r_and;
        logic r_or;
        logic r_xor;
        logic result;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            if (i < int'(n)) begin
                r_and = r_and & vec[i];
                r_or  = r_or  | vec[i];
                r_xor = r_xor ^ vec[i];
            end
        end
        case (mode)
            MODE_AND:  result = r_and;
            MODE_OR:   result = r_or;
            MODE_XOR:  result = r_xor;
            MODE_NAND: result = ~r_and;
            MODE_NOR:  result = ~r_or;
            MODE_XNOR: result = ~r_xor;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/gate_input_debouncer.sv
// ---------------------------------------------------------------------------
// gate_input_debouncer
// One asynchronous, bouncing input bit -> 2-flop synchroniser -> debouncer.
// A new level is accepted only after the synchronised input has disagreed
// with the accepted level for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk    in   board clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   raw asynchronous input
//   level  out  accepted (debounced) level, registered
// ---------------------------------------------------------------------------
module gate_input_debouncer
    import multi_gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // ---- stage p0/p1: metastability synchroniser ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: debounce counter and accepted level ----
    // Any cycle of agreement restarts the count, so only an uninterrupted
    // run of disagreement flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync_p1 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_p1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_gate_demonstration.sv
// ---------------------------------------------------------------------------
// multi_gate_demonstration
// N_INPUTS switches and a mode button, all debounced. The button steps
// through six reduction-gate modes; the registered gate result, the
// debounced switches and the current mode are shown on LEDs.
// Ports:
//   I_P_CLK       in   100 MHz board clock
//   I_P_RST_N     in   asynchronous active-low reset
//   I_P_SW        in   raw switches [N_INPUTS]
//   I_P_BTN_MODE  in   raw mode push-button, active-high
//   O_P_LED_SW    out  debounced switch levels [N_INPUTS]
//   O_P_LED_MODE  out  current mode, binary [3]
//   O_P_LED_GATE  out  registered gate result
// ---------------------------------------------------------------------------
module multi_gate_demonstration
    import multi_gate_pkg::*;
#(
    parameter int N_INPUTS        = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                I_P_CLK,
    input  logic                I_P_RST_N,
    input  logic [N_INPUTS-1:0] I_P_SW,
    input  logic                I_P_BTN_MODE,
    output logic [N_INPUTS-1:0] O_P_LED_SW,
    output logic [MODE_W-1:0]   O_P_LED_MODE,
    output logic                O_P_LED_GATE
);

    // Button occupies the top bit so the switches keep their own indices.
    logic [N_INPUTS:0]       raw_all;
    logic [N_INPUTS:0]       level_all;
    logic [N_INPUTS-1:0]     sw_level;
    logic                    btn_level;
    logic                    btn_prev;
    logic [MODE_W-1:0]       mode;
    logic [MAX_INPUTS-1:0]   sw_wide;

    assign raw_all   = {I_P_BTN_MODE, I_P_SW};
    assign sw_level  = level_all[N_INPUTS-1:0];
    assign btn_level = level_all[N_INPUTS];
    assign sw_wide   = MAX_INPUTS'(sw_level);

    for (genvar i = 0; i <= N_INPUTS; i++) begin : g_db
        gate_input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (I_P_CLK),
            .rst_n(I_P_RST_N),
            .raw  (raw_all[i]),
            .level(level_all[i])
        );
    end

    // ---- stage p3: button edge detect, mode register, gate register ----
    // Only the debounced rising edge advances the mode; anything at or past
    // the last legal code (including unreachable 6/7) wraps to AND.
    always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
        if (!I_P_RST_N) begin
            btn_prev     <= 1'b0;
            mode         <= MODE_AND;
            O_P_LED_GATE <= 1'b0;
        end else begin
            btn_prev <= btn_level;
            if (btn_level && !btn_prev) begin
                if (mode >= MODE_W'(MODE_COUNT - 1))
                    mode <= MODE_AND;
                else
                    mode <= mode + MODE_W'(1);
            end
            O_P_LED_GATE <= gate_eval(mode, sw_wide, N_INPUTS);
        end
    end

    assign O_P_LED_SW   = sw_level;
    assign O_P_LED_MODE = mode;

endmodule
